// File: rtl/ptw_dmem_bridge.sv
// Page-table-walker to L1 dcache bridge: one outstanding PTE read, response watchdog,
// and discard of dcache responses that arrive after the walk was abandoned.
module ptw_dmem_bridge #(
  parameter int PADDR_W = 40,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ptw_req_valid_i,
  input  logic [PADDR_W-1:0] ptw_req_addr_i,
  output logic               ptw_dmem_ready_o,
  output logic               ptw_resp_valid_o,
  output logic               ptw_resp_nack_o,
  output logic [63:0]        ptw_resp_data_o,
  input  logic               flush_i,
  output logic               dc_req_valid_o,
  input  logic               dc_req_ready_i,
  output logic [PADDR_W-1:0] dc_req_addr_o,
  output logic [4:0]         dc_req_cmd_o,
  output logic [3:0]         dc_req_typ_o,
  input  logic               dc_resp_valid_i,
  input  logic               dc_resp_err_i,
  input  logic [63:0]        dc_resp_data_i,
  output logic               pmu_timeout_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [PADDR_W-1:0] addr_reg, addr_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [63:0]        data_reg, data_next;
  logic               resp_valid_reg, resp_valid_next;
  logic               resp_nack_reg, resp_nack_next;
  logic               pmu_reg, pmu_next;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      timer_reg      <= '0;
      data_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_nack_reg  <= 1'b0;
      pmu_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      timer_reg      <= timer_next;
      data_reg       <= data_next;
      resp_valid_reg <= resp_valid_next;
      resp_nack_reg  <= resp_nack_next;
      pmu_reg        <= pmu_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    timer_next      = timer_reg;
    data_next       = data_reg;
    resp_valid_next = 1'b0;
    resp_nack_next  = 1'b0;
    pmu_next        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ptw_req_valid_i && !flush_i) begin
          addr_next  = ptw_req_addr_i;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // A flush racing the handshake still owes us a response, so drain it.
        if (dc_req_ready_i) begin
          timer_next = '0;
          state_next = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (timer_reg != T_SAT) timer_next = timer_reg + 1'b1;
        if (dc_resp_valid_i && !dc_resp_err_i) begin
          data_next       = dc_resp_data_i;
          resp_valid_next = 1'b1;
          state_next      = IDLE;
        end else if (dc_resp_valid_i) begin
          resp_nack_next = 1'b1;
          state_next     = IDLE;
        end else if (flush_i) begin
          state_next = DRAIN;
        end else if (timer_reg == T_LAST) begin
          resp_nack_next = 1'b1;
          pmu_next       = 1'b1;
          state_next     = DRAIN;
        end
      end
      DRAIN: begin
        if (dc_resp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ptw_dmem_ready_o = (state_reg == IDLE) && !flush_i;
  assign dc_req_valid_o   = (state_reg == ISSUE);
  assign dc_req_addr_o    = addr_reg;
  assign dc_req_cmd_o     = 5'b00000;
  assign dc_req_typ_o     = 4'b0011;
  assign ptw_resp_valid_o = resp_valid_reg;
  assign ptw_resp_nack_o  = resp_nack_reg;
  assign ptw_resp_data_o  = data_reg;
  assign pmu_timeout_o    = pmu_reg;

endmodule

// File: tb/tb_ptw_dmem_bridge.sv
// Bench for ptw_dmem_bridge: directed table, hand-written flush/reset sequences, and
// random transactions checked against a transaction-level outcome model.
module tb_ptw_dmem_bridge;
  localparam int TO = 4;
  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ptw_req_valid;
  logic [AW-1:0] ptw_req_addr;
  logic          ptw_dmem_ready;
  logic          ptw_resp_valid;
  logic          ptw_resp_nack;
  logic [63:0]   ptw_resp_data;
  logic          flush;
  logic          dc_req_valid;
  logic          dc_req_ready;
  logic [AW-1:0] dc_req_addr;
  logic [4:0]    dc_req_cmd;
  logic [3:0]    dc_req_typ;
  logic          dc_resp_valid;
  logic          dc_resp_err;
  logic [63:0]   dc_resp_data;
  logic          pmu_timeout;

  always #5 clk = ~clk;

  ptw_dmem_bridge #(.PADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ptw_req_valid_i(ptw_req_valid), .ptw_req_addr_i(ptw_req_addr),
    .ptw_dmem_ready_o(ptw_dmem_ready), .ptw_resp_valid_o(ptw_resp_valid),
    .ptw_resp_nack_o(ptw_resp_nack), .ptw_resp_data_o(ptw_resp_data),
    .flush_i(flush), .dc_req_valid_o(dc_req_valid), .dc_req_ready_i(dc_req_ready),
    .dc_req_addr_o(dc_req_addr), .dc_req_cmd_o(dc_req_cmd), .dc_req_typ_o(dc_req_typ),
    .dc_resp_valid_i(dc_resp_valid), .dc_resp_err_i(dc_resp_err),
    .dc_resp_data_i(dc_resp_data), .pmu_timeout_o(pmu_timeout)
  );

  // kind: 0 no response, 1 good PTE, 2 error nack, 3 timeout nack+pmu
  typedef struct {
    logic [AW-1:0] addr;
    int            stall;
    int            d;
    bit            err;
    logic [63:0]   data;
    int            f;
    int            kind;
    int            ec;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_good = '0;
  vec_t        tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // d: WAIT cycle (1 = cycle after handshake) carrying the response; f: WAIT cycle of flush, 0 = none.
  task automatic predict(input int d, input bit err, input int f, output int kind, output int ec);
    if (d <= TO && !(f >= 1 && f < d)) begin
      kind = err ? 2 : 1;
      ec   = d + 1;
    end else if (f >= 1 && f < d && f <= TO) begin
      kind = 0;
      ec   = -1;
    end else begin
      kind = 3;
      ec   = TO + 1;
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [4:0] exp;
    ptw_req_valid = 1'b1;
    ptw_req_addr  = v.addr;
    #1;
    check("accept_ready", 64'(ptw_dmem_ready), 64'd1);
    step();
    ptw_req_valid = 1'b0;
    ptw_req_addr  = {8'($urandom), $urandom};
    for (int k = 0; k < v.stall; k++) begin
      dc_req_ready = 1'b0;
      #1;
      check($sformatf("issue_hold_%0d", k), 64'({ptw_dmem_ready, dc_req_valid, dc_req_addr}),
            64'({1'b0, 1'b1, v.addr}));
      step();
    end
    dc_req_ready = 1'b1;
    #1;
    check("issue_hs", 64'({ptw_dmem_ready, dc_req_valid, dc_req_addr, dc_req_cmd, dc_req_typ}),
          64'({1'b0, 1'b1, v.addr, 5'b00000, 4'b0011}));
    step();
    dc_req_ready = 1'b0;
    for (int c = 1; c <= v.d + 1; c++) begin
      dc_resp_valid = (c == v.d);
      dc_resp_err   = (c == v.d) ? v.err : 1'($urandom);
      dc_resp_data  = (c == v.d) ? v.data : {$urandom, $urandom};
      flush         = (c == v.f) && (c <= v.d);
      #1;
      exp = {c == v.d + 1, 1'b0, v.kind == 1 && c == v.ec,
             (v.kind == 2 || v.kind == 3) && c == v.ec, v.kind == 3 && c == v.ec};
      if (v.kind == 1 && c == v.ec) last_good = v.data;
      check($sformatf("flags_c%0d_k%0d", c, v.kind),
            64'({ptw_dmem_ready, dc_req_valid, ptw_resp_valid, ptw_resp_nack, pmu_timeout}), 64'(exp));
      check($sformatf("data_c%0d", c), ptw_resp_data, last_good);
      if (c <= v.d) step();
    end
    dc_resp_valid = 1'b0;
    dc_resp_err   = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    int idle_n;
    vec_t v;
    rstn = 1'b0; ptw_req_valid = 1'b0; ptw_req_addr = '0; flush = 1'b0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_err = 1'b0; dc_resp_data = '0;

    //            addr            stall d err data                 f kind ec
    tbl[0] = '{40'h0080001000, 0, 1, 1'b0, 64'h20000C01,         0, 1, 2};
    tbl[1] = '{40'h0080002008, 5, 1, 1'b0, 64'h1234_5678_9ABC_DEF1, 0, 1, 2};
    tbl[2] = '{40'h00FFFFFFF8, 0, 2, 1'b1, 64'hDEAD_BEEF_0000_0001, 0, 2, 3};
    tbl[3] = '{40'h0080003000, 1, 8, 1'b0, 64'h5555_AAAA_5555_AAAA, 0, 3, 5};
    tbl[4] = '{40'h0080004000, 0, 3, 1'b0, 64'h0BAD_0BAD_0BAD_0BAD, 1, 0, -1};
    tbl[5] = '{40'h0080005000, 2, 2, 1'b0, 64'h0000_0000_2000_0C0F, 2, 1, 3};
    tbl[6] = '{40'h0080006000, 0, 6, 1'b0, 64'hFFFF_0000_FFFF_0000, 4, 0, -1};
    tbl[7] = '{40'h0080007000, 0, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1, 5};
    tbl[8] = '{40'h0080008000, 0, 4, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 0, 2, 5};

    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({ptw_dmem_ready, dc_req_valid, ptw_resp_valid, ptw_resp_nack, pmu_timeout}),
          64'b10000);
    check("reset_regs", 64'(dc_req_addr) | ptw_resp_data, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("post_reset_ready", 64'(ptw_dmem_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
      step();
    end

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; ptw_req_valid = 1'b1; ptw_req_addr = 40'h0011223344;
    #1;
    check("idle_flush_ready", 64'(ptw_dmem_ready), 64'd0);
    step();
    flush = 1'b0; ptw_req_valid = 1'b0;
    #1;
    check("idle_flush_noreq", 64'({ptw_dmem_ready, dc_req_valid}), 64'b10);
    step();

    // Flush in ISSUE without handshake: straight back to IDLE.
    ptw_req_valid = 1'b1; ptw_req_addr = 40'h0080009000;
    step();
    ptw_req_valid = 1'b0; flush = 1'b1; dc_req_ready = 1'b0;
    #1;
    check("issue_flush_valid", 64'({ptw_dmem_ready, dc_req_valid}), 64'b01);
    step();
    flush = 1'b0;
    #1;
    check("issue_flush_idle", 64'({ptw_dmem_ready, dc_req_valid}), 64'b10);
    step();

    // Flush coinciding with handshake: DRAIN, flush ignored there, response discarded.
    ptw_req_valid = 1'b1; ptw_req_addr = 40'h008000A000;
    step();
    ptw_req_valid = 1'b0; flush = 1'b1; dc_req_ready = 1'b1;
    #1;
    step();
    flush = 1'b0; dc_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      #1;
      check($sformatf("drain_wait_%0d", k),
            64'({ptw_dmem_ready, dc_req_valid, ptw_resp_valid, ptw_resp_nack, pmu_timeout}), 64'd0);
      step();
    end
    flush = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = 64'hBADB_BADB_BADB_BADB;
    step();
    dc_resp_valid = 1'b0;
    #1;
    check("drain_exit", 64'({ptw_dmem_ready, dc_req_valid, ptw_resp_valid, ptw_resp_nack, pmu_timeout}),
          64'b10000);
    check("drain_data_kept", ptw_resp_data, last_good);
    step();

    // Reset mid-operation returns to IDLE at once and clears registers.
    ptw_req_valid = 1'b1; ptw_req_addr = 40'h008000B000;
    step();
    ptw_req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    last_good = '0;
    check("midop_reset", 64'({ptw_dmem_ready, dc_req_valid}), 64'b10);
    check("midop_reset_data", ptw_resp_data, last_good);
    @(negedge clk);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 40; i++) begin
      v.addr  = {8'($urandom), $urandom};
      v.data  = {$urandom, $urandom};
      v.stall = $urandom_range(0, 3);
      v.d     = $urandom_range(1, 7);
      v.err   = 1'($urandom_range(0, 1));
      v.f     = $urandom_range(0, 7);
      predict(v.d, v.err, v.f, v.kind, v.ec);
      run_txn(v);
      idle_n = $urandom_range(1, 3);
      repeat (idle_n) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
